// File: rtl/norm_gain_pkg.sv
// ============================================================================
// Module   : norm_gain_pkg
// Brief    : Shared widths, constants and state encoding for normalized-gain stages.
// Revision : 1.0
// ============================================================================
`default_nettype none

package norm_gain_pkg;

  localparam int          DATA_W_DEF = 16;
  localparam int          COEF_W     = 18;
  localparam int          FRAC_W     = 16;
  localparam int          ACC_W      = 34;
  localparam logic [17:0] COEF_ONE   = 18'h10000;
  localparam logic [15:0] ROUND_HALF = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/norm_gain_if.sv
// ============================================================================
// Module   : norm_gain_if
// Brief    : Operand-in / result-out valid-ready bundle for the gain multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface norm_gain_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample;
  logic [COEF_W-1:0] in_coef;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;

  modport master (
    output in_valid, in_sample, in_coef, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_sample, in_coef, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

`default_nettype wire

// File: rtl/norm_gain_sat.sv
// ============================================================================
// Module   : norm_gain_sat
// Brief    : Round (NORM_GAIN_ROUND_EN), drop FRAC_W bits, saturate to DATA_W.
// Revision : 1.0
// ============================================================================
`default_nettype none

module norm_gain_sat
  import norm_gain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = norm_gain_pkg::ACC_W,
  parameter int FW     = norm_gain_pkg::FRAC_W
) (
  input  logic [AW-1:0]     acc_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sat_o
);

  // One guard bit keeps the rounding add from ever wrapping.
  logic [AW:0] w_sum;
  logic [AW:0] w_q;

`ifdef NORM_GAIN_ROUND_EN
  assign w_sum = {1'b0, acc_i} + (AW+1)'(ROUND_HALF);
`else
  assign w_sum = {1'b0, acc_i};
`endif

  assign w_q    = w_sum >> FW;
  assign sat_o  = |w_q[AW:DATA_W];
  assign data_o = sat_o ? {DATA_W{1'b1}} : w_q[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/norm_gain_mult.sv
// ============================================================================
// Module   : norm_gain_mult
// Brief    : Serial shift-add sample x 2.16 coefficient multiply with saturation;
//            rounding enabled by NORM_GAIN_ROUND_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module norm_gain_mult
  import norm_gain_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = norm_gain_pkg::COEF_W,
  parameter int FRAC_W = norm_gain_pkg::FRAC_W
) (
  input  logic       clk,
  input  logic       rst,
  norm_gain_if.slave bus
);

  localparam int AW    = DATA_W + COEF_W;
  localparam int CNT_W = $clog2(COEF_W + 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     samp_q, samp_d;
  logic [COEF_W-1:0] coef_q, coef_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;

  logic [DATA_W-1:0] w_sat_data;
  logic              w_sat;

  norm_gain_sat #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .FW     (FRAC_W)
  ) u_sat (
    .acc_i  (acc_q),
    .data_o (w_sat_data),
    .sat_o  (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      samp_q     <= '0;
      coef_q     <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      samp_q     <= samp_d;
      coef_q     <= coef_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    samp_d     = samp_q;
    coef_d     = coef_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          samp_d  = AW'(bus.in_sample);
          coef_d  = bus.in_coef;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Final accumulator is registered into the result on the cycle after the last step.
        if (cnt_q == CNT_W'(COEF_W)) begin
          out_data_d = w_sat_data;
          out_sat_d  = w_sat;
          state_d    = DONE;
        end else begin
          if (coef_q[0]) begin
            acc_d = acc_q + samp_q;
          end
          samp_d = samp_q << 1;
          coef_d = coef_q >> 1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

`default_nettype wire
